// File: rtl/ct_stream_splitter.sv
// Ciphertext splitter: loads a wide bus chunk-by-chunk into a buffer, then serves words
// by random-access read and, when CT_SPLIT_STREAM_EN is defined, a valid/ready stream.
module ct_stream_splitter #(
  parameter int IN_WIDTH    = 6144,
  parameter int CHUNK_WIDTH = 256,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_chomp,
  input  logic [IN_WIDTH-1:0]   i_data_in,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WORD_WIDTH-1:0] o_data_out,
  output logic                  o_outready,
  input  logic                  i_tready,
  output logic                  o_tvalid,
  output logic [WORD_WIDTH-1:0] o_tdata,
  output logic                  o_tlast
);

  localparam int N_CHUNKS = IN_WIDTH / CHUNK_WIDTH;
  localparam int N_WORDS  = IN_WIDTH / WORD_WIDTH;
  localparam int WPC      = CHUNK_WIDTH / WORD_WIDTH;
  localparam int CIW      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int SW       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int SH_W     = $clog2(IN_WIDTH) + 1;

  if ((IN_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
    $error("ct_stream_splitter: IN_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  if ((CHUNK_WIDTH % WORD_WIDTH) != 0) begin : g_bad_word
    $error("ct_stream_splitter: CHUNK_WIDTH must be a multiple of WORD_WIDTH");
  end
  if ((2 ** ADDR_WIDTH) < N_WORDS) begin : g_bad_addr
    $error("ct_stream_splitter: ADDR_WIDTH too small to address every word");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_e;

  state_e                  state_q, state_d;
  logic [CIW-1:0]          cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   data_out_q, data_out_d;
  logic [CHUNK_WIDTH-1:0]  mem_q [N_CHUNKS];
  logic                    wr_en;
  logic [CHUNK_WIDTH-1:0]  wr_chunk;
  logic                    load_done;

  // Word 0 sits in the top bits of chunk 0 (MSB-first ordering).
  function automatic logic [WORD_WIDTH-1:0] word_at(input int unsigned w);
    int unsigned            ci;
    int unsigned            wi;
    logic [CHUNK_WIDTH-1:0] chunk;
    word_at = '0;
    if (w < N_WORDS) begin
      ci      = w / WPC;
      wi      = w % WPC;
      chunk   = mem_q[CIW'(ci)];
      word_at = WORD_WIDTH'(chunk >> SH_W'(CHUNK_WIDTH - (wi + 1) * WORD_WIDTH));
    end
  endfunction

  assign load_done = (state_q == LOAD) && (cnt_q == CIW'(N_CHUNKS - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_chunk = CHUNK_WIDTH'(i_data_in >> SH_W'(IN_WIDTH - (32'(cnt_q) + 1) * CHUNK_WIDTH));
    case (state_q)
      IDLE: begin
        if (i_chomp) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        wr_en = 1'b1;
        if (load_done) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CIW'(1);
        end
      end
      READY: begin
        if (i_chomp) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_out_d = '0;
    if (state_q == READY) begin
      data_out_d = word_at(32'(i_addr));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Buffer contents need no reset; they are only observable in READY.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[cnt_q] <= wr_chunk;
    end
  end

  assign o_data_out = data_out_q;
  assign o_outready = (state_q == READY);

`ifdef CT_SPLIT_STREAM_EN
  logic [SW-1:0]         str_cnt_q, str_cnt_d;
  logic                  tvalid_q, tvalid_d;
  logic                  str_last;
  logic [WORD_WIDTH-1:0] tdata_w;

  always_comb begin
    str_cnt_d = str_cnt_q;
    tvalid_d  = tvalid_q;
    str_last  = (str_cnt_q == SW'(N_WORDS - 1));
    if (load_done) begin
      tvalid_d  = 1'b1;
      str_cnt_d = '0;
    end else if ((state_q == READY) && i_chomp) begin
      tvalid_d  = 1'b0;
      str_cnt_d = '0;
    end else if (tvalid_q && i_tready) begin
      if (str_last) begin
        tvalid_d = 1'b0;
      end else begin
        str_cnt_d = str_cnt_q + SW'(1);
      end
    end
  end

  always_comb begin
    tdata_w = '0;
    if (tvalid_q) begin
      tdata_w = word_at(32'(str_cnt_q));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      str_cnt_q <= '0;
      tvalid_q  <= 1'b0;
    end else begin
      str_cnt_q <= str_cnt_d;
      tvalid_q  <= tvalid_d;
    end
  end

  assign o_tvalid = tvalid_q;
  assign o_tlast  = tvalid_q && str_last;
  assign o_tdata  = tdata_w;
`else
  logic unused_tready;
  assign unused_tready = i_tready;
  assign o_tvalid      = 1'b0;
  assign o_tlast       = 1'b0;
  assign o_tdata       = '0;
`endif

endmodule

// File: tb/tb_ct_stream_splitter.sv
// Directed bench for ct_stream_splitter: table-driven read-port vectors plus
// hand-written load, stall, reload and reset sequences.
module tb_ct_stream_splitter;

  localparam int IN_W = 6144;
  localparam int NW   = 192;

  logic            clk = 1'b0;
  logic            i_resetn;
  logic            i_chomp;
  logic [IN_W-1:0] i_data_in;
  logic [7:0]      i_addr;
  logic [31:0]     o_data_out;
  logic            o_outready;
  logic            i_tready;
  logic            o_tvalid;
  logic [31:0]     o_tdata;
  logic            o_tlast;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t         rd_tab[8];
  logic [IN_W-1:0] data_a;
  logic [IN_W-1:0] data_b;

  always #5 clk = ~clk;

  ct_stream_splitter dut (
    .i_clk      (clk),
    .i_resetn   (i_resetn),
    .i_chomp    (i_chomp),
    .i_data_in  (i_data_in),
    .i_addr     (i_addr),
    .o_data_out (o_data_out),
    .o_outready (o_outready),
    .i_tready   (i_tready),
    .o_tvalid   (o_tvalid),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast)
  );

  function automatic logic [31:0] word_a(input int w);
    return 32'hC0DE_0000 + 32'(w);
  endfunction

  function automatic logic [31:0] word_b(input int w);
    return 32'hA500_0000 + 32'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr);
    i_addr = addr;
    tick();
  endtask

  task automatic checkStream(input string name, input logic v, input logic [31:0] d, input logic l);
`ifdef CT_SPLIT_STREAM_EN
    checkOutput({name, "_tvalid"}, 32'(o_tvalid), 32'(v));
    checkOutput({name, "_tdata"}, o_tdata, d);
    checkOutput({name, "_tlast"}, 32'(o_tlast), 32'(l));
`else
    checkOutput({name, "_tvalid"}, 32'(o_tvalid), 32'(1'b0 & v));
    checkOutput({name, "_tdata"}, o_tdata, d & 32'h0);
    checkOutput({name, "_tlast"}, 32'(o_tlast), 32'(1'b0 & l));
`endif
  endtask

  // Chomp sampled at the next edge; optional extra chomp injected inject_at edges later.
  task automatic loadAndWait(input logic [IN_W-1:0] data, input int inject_at, input string name);
    int n;
    i_data_in = data;
    i_chomp   = 1'b1;
    tick();
    i_chomp = 1'b0;
    checkOutput({name, "_outready_drop"}, 32'(o_outready), 32'd0);
    checkOutput({name, "_tvalid_drop"}, 32'(o_tvalid), 32'd0);
    n = 0;
    while (!o_outready && n < 60) begin
      i_chomp = (n + 1 == inject_at);
      tick();
      n++;
    end
    i_chomp = 1'b0;
    checkOutput({name, "_latency"}, 32'(n), 32'd24);
  endtask

  initial begin
    int n;
    int idx;
    bit pat[4];

    i_resetn  = 1'b0;
    i_chomp   = 1'b0;
    i_data_in = '0;
    i_addr    = '0;
    i_tready  = 1'b0;
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int w = 0; w < NW; w++) begin
      data_a[IN_W-1-w*32 -: 32] = word_a(w);
      data_b[IN_W-1-w*32 -: 32] = word_b(w);
    end

    rd_tab[0] = '{"rd_addr0",   8'd0,   32'hC0DE_0000};
    rd_tab[1] = '{"rd_addr5",   8'd5,   32'hC0DE_0005};
    rd_tab[2] = '{"rd_addr7",   8'd7,   32'hC0DE_0007};
    rd_tab[3] = '{"rd_addr8",   8'd8,   32'hC0DE_0008};
    rd_tab[4] = '{"rd_addr100", 8'd100, 32'hC0DE_0064};
    rd_tab[5] = '{"rd_addr191", 8'd191, 32'hC0DE_00BF};
    rd_tab[6] = '{"rd_addr192", 8'd192, 32'h0000_0000};
    rd_tab[7] = '{"rd_addr255", 8'd255, 32'h0000_0000};

    tick();
    tick();
    checkOutput("reset_outready", 32'(o_outready), 32'd0);
    checkOutput("reset_data_out", o_data_out, 32'd0);
    checkStream("reset", 1'b0, 32'd0, 1'b0);
    i_resetn = 1'b1;
    tick();

    i_addr = 8'd5;
    loadAndWait(data_a, 0, "t1");
    checkStream("t1_head", 1'b1, word_a(0), 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(rd_tab[i].addr);
      checkOutput(rd_tab[i].name, o_data_out, rd_tab[i].exp);
    end
    checkStream("t2_hold", 1'b1, word_a(0), 1'b0);

`ifdef CT_SPLIT_STREAM_EN
    i_tready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      checkOutput("t3_tvalid", 32'(o_tvalid), 32'd1);
      checkOutput("t3_tdata", o_tdata, word_a(i));
      checkOutput("t3_tlast", 32'(o_tlast), (i == NW - 1) ? 32'd1 : 32'd0);
      tick();
    end
    i_tready = 1'b0;
    checkStream("t3_done", 1'b0, 32'd0, 1'b0);

    loadAndWait(data_a, 0, "t4_load");
    idx = 0;
    for (int c = 0; c < 800 && idx < NW; c++) begin
      i_tready = pat[c % 4];
      checkOutput("t4_tvalid", 32'(o_tvalid), 32'd1);
      checkOutput("t4_tdata", o_tdata, word_a(idx));
      tick();
      if (pat[c % 4]) idx++;
    end
    i_tready = 1'b0;
    checkOutput("t4_count", 32'(idx), 32'(NW));
    checkStream("t4_done", 1'b0, 32'd0, 1'b0);
`else
    i_tready = 1'b1;
    repeat (4) tick();
    i_tready = 1'b0;
    checkStream("t3_tied", 1'b0, 32'd0, 1'b0);
`endif

    loadAndWait(data_a, 10, "t5a");
    checkStream("t5a_head", 1'b1, word_a(0), 1'b0);
    applyStimulus(8'd5);
    checkOutput("t5a_rd5", o_data_out, word_a(5));

    i_tready = 1'b1;
    repeat (5) tick();
    i_tready = 1'b0;
    checkStream("t5_mid", 1'b1, word_a(5), 1'b0);

    loadAndWait(data_b, 0, "t5b");
    checkStream("t5b_head", 1'b1, word_b(0), 1'b0);
    applyStimulus(8'd5);
    checkOutput("t5b_rd5", o_data_out, word_b(5));
    applyStimulus(8'd191);
    checkOutput("t5b_rd191", o_data_out, word_b(191));

    i_addr    = 8'd5;
    i_data_in = data_a;
    i_chomp   = 1'b1;
    tick();
    i_chomp = 1'b0;
    repeat (11) tick();
    checkOutput("t6_load_rd", o_data_out, 32'd0);
    i_resetn = 1'b0;
    tick();
    i_resetn = 1'b1;
    checkOutput("t6_rst_outready", 32'(o_outready), 32'd0);
    checkOutput("t6_rst_data_out", o_data_out, 32'd0);
    checkStream("t6_rst", 1'b0, 32'd0, 1'b0);
    n = 0;
    repeat (30) begin
      tick();
      if (o_outready) n++;
    end
    checkOutput("t6_idle", 32'(n), 32'd0);

    loadAndWait(data_b, 0, "t6_reload");
    checkStream("t6_head", 1'b1, word_b(0), 1'b0);
    applyStimulus(8'd0);
    checkOutput("t6_rd0", o_data_out, word_b(0));
    applyStimulus(8'd100);
    checkOutput("t6_rd100", o_data_out, word_b(100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
